multicycle_ctrl: RTL

//  Multicycle control FSM that sequences the RV32I datapath (PC reg, regfile, ALU).

---
 rtl/multicycle_ctrl.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback,
// handshakes with a shared variable-latency memory, counts retired instructions.
module multicycle_ctrl #(
  parameter int unsigned ALU_CTRL_W = 3,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           instr,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  adrSrc,
  output logic                  memWrite,
  output logic                  irWrite,
  output logic                  pcWrite,
  output logic                  pcSrc,
  output logic                  regWrite,
  output logic [1:0]            resultSrc,
  output logic                  ALUSrc,
  output logic [ALU_CTRL_W-1:0] ALUControl,
  output logic                  halted,
  output logic [CNT_W-1:0]      instret
);

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StExecR,
    StExecI,
    StMemAddr,
    StMemRd,
    StMemWr,
    StWbAlu,
    StWbMem,
    StBranch,
    StJal,
    StHalt
  } state_e;

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpI      = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluXor = 3'b100;
  localparam logic [2:0] AluSlt = 3'b101;
  localparam logic [2:0] AluSll = 3'b110;
  localparam logic [2:0] AluSrl = 3'b111;

  state_e state_q, state_d;

  // Instruction fields captured in DECODE so later states do not depend on IR timing.
  logic [6:0] op_q, op_d;
  logic [2:0] f3_q, f3_d;
  logic       f7b5_q, f7b5_d;
  logic [4:0] rd_q, rd_d;

  logic                  mem_req_q, mem_req_d;
  logic                  adr_src_q, adr_src_d;
  logic                  mem_write_q, mem_write_d;
  logic                  reg_write_q, reg_write_d;
  logic [1:0]            result_src_q, result_src_d;
  logic                  alu_src_q, alu_src_d;
  logic [ALU_CTRL_W-1:0] alu_ctrl_q, alu_ctrl_d;
  logic                  pc_src_q, pc_src_d;
  logic                  halted_q, halted_d;
  logic [CNT_W-1:0]      instret_q, instret_d;

  logic ack;
  logic retire;
  logic br_take;
  logic unused_instr;

  assign unused_instr = ^{instr[31], instr[29:15]};

  function automatic logic [ALU_CTRL_W-1:0] alu_dec(input logic [2:0] f3, input logic sub_en);
    logic [2:0] code;
    case (f3)
      3'b000:         code = sub_en ? AluSub : AluAdd;
      3'b001:         code = AluSll;
      3'b010, 3'b011: code = AluSlt;
      3'b100:         code = AluXor;
      3'b101:         code = AluSrl;
      3'b110:         code = AluOr;
      default:        code = AluAnd;
    endcase
    return ALU_CTRL_W'(code);
  endfunction

  // An ack only counts while a request is actually outstanding and not being reset.
  assign ack = reset & mem_req_q & mem_ready;

  always_comb begin
    br_take = 1'b0;
    if (f3_q == 3'b000) begin
      br_take = zero;
    end else if (f3_q == 3'b001) begin
      br_take = ~zero;
    end
  end

  always_comb begin
    op_d   = op_q;
    f3_d   = f3_q;
    f7b5_d = f7b5_q;
    rd_d   = rd_q;
    if (state_q == StDecode) begin
      op_d   = instr[6:0];
      f3_d   = instr[14:12];
      f7b5_d = instr[30];
      rd_d   = instr[11:7];
    end
  end

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      StFetch: begin
        if (ack) state_d = StDecode;
      end
      StDecode: begin
        case (instr[6:0])
          OpR:             state_d = StExecR;
          OpI:             state_d = StExecI;
          OpLoad, OpStore: state_d = StMemAddr;
          OpBranch:        state_d = StBranch;
          OpJal:           state_d = StJal;
          OpSystem: begin
            state_d = StHalt;
            retire  = 1'b1;
          end
          default:         state_d = StHalt;
        endcase
      end
      StExecR, StExecI: state_d = StWbAlu;
      StMemAddr:        state_d = (op_q == OpStore) ? StMemWr : StMemRd;
      StMemRd: begin
        if (ack) state_d = StWbMem;
      end
      StMemWr: begin
        if (ack) begin
          state_d = StFetch;
          retire  = 1'b1;
        end
      end
      StWbAlu, StWbMem, StBranch, StJal: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StHalt:  state_d = StHalt;
      default: state_d = StFetch;
    endcase
  end

  assign instret_d = instret_q + CNT_W'(retire);

  // Moore outputs for the state being entered, so they are registered at the boundary.
  always_comb begin
    mem_req_d    = 1'b0;
    adr_src_d    = 1'b0;
    mem_write_d  = 1'b0;
    reg_write_d  = 1'b0;
    result_src_d = 2'b00;
    alu_src_d    = 1'b0;
    alu_ctrl_d   = ALU_CTRL_W'(AluAdd);
    pc_src_d     = 1'b0;
    halted_d     = 1'b0;
    case (state_d)
      StFetch: mem_req_d = 1'b1;
      StExecR: alu_ctrl_d = alu_dec(f3_d, f7b5_d);
      StExecI: begin
        alu_src_d  = 1'b1;
        alu_ctrl_d = alu_dec(f3_d, 1'b0);
      end
      StMemAddr: alu_src_d = 1'b1;
      StMemRd: begin
        mem_req_d = 1'b1;
        adr_src_d = 1'b1;
      end
      StMemWr: begin
        mem_req_d   = 1'b1;
        adr_src_d   = 1'b1;
        mem_write_d = 1'b1;
      end
      StWbAlu: reg_write_d = (rd_d != 5'd0);
      StWbMem: begin
        reg_write_d  = (rd_d != 5'd0);
        result_src_d = 2'b01;
      end
      StBranch: begin
        alu_ctrl_d = ALU_CTRL_W'(AluSub);
        pc_src_d   = 1'b1;
      end
      StJal: begin
        reg_write_d  = (rd_d != 5'd0);
        result_src_d = 2'b10;
        pc_src_d     = 1'b1;
      end
      StHalt:  halted_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StFetch;
      op_q         <= '0;
      f3_q         <= '0;
      f7b5_q       <= 1'b0;
      rd_q         <= '0;
      mem_req_q    <= 1'b0;
      adr_src_q    <= 1'b0;
      mem_write_q  <= 1'b0;
      reg_write_q  <= 1'b0;
      result_src_q <= 2'b00;
      alu_src_q    <= 1'b0;
      alu_ctrl_q   <= '0;
      pc_src_q     <= 1'b0;
      halted_q     <= 1'b0;
      instret_q    <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      f3_q         <= f3_d;
      f7b5_q       <= f7b5_d;
      rd_q         <= rd_d;
      mem_req_q    <= mem_req_d;
      adr_src_q    <= adr_src_d;
      mem_write_q  <= mem_write_d;
      reg_write_q  <= reg_write_d;
      result_src_q <= result_src_d;
      alu_src_q    <= alu_src_d;
      alu_ctrl_q   <= alu_ctrl_d;
      pc_src_q     <= pc_src_d;
      halted_q     <= halted_d;
      instret_q    <= instret_d;
    end
  end

  // IR/PC capture must coincide with the fetch ack; branch decision needs the live zero flag.
  assign irWrite = (state_q == StFetch) & ack;
  assign pcWrite = irWrite | (reset & (state_q == StJal))
                 | (reset & (state_q == StBranch) & br_take);

  assign mem_req    = mem_req_q;
  assign adrSrc     = adr_src_q;
  assign memWrite   = mem_write_q;
  assign regWrite   = reg_write_q;
  assign resultSrc  = result_src_q;
  assign ALUSrc     = alu_src_q;
  assign ALUControl = alu_ctrl_q;
  assign pcSrc      = pc_src_q;
  assign halted     = halted_q;
  assign instret    = instret_q;

endmodule
